rv_rr_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (issue port, memory request slot, writeback bus) among `NUM_REQS` requesters. It wraps the team's priority-encoder datapath with a rotating priority pointer and a valid/ready lock, so a grant stays stable until the downstream accepts it. Sits between per-warp/per-lane request queues and the shared unit.

---
 rtl/rv_rr_grant_arbiter.sv | 117 +++++++++++
 tb/tb_rv_rr_grant_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rv_rr_grant_arbiter.sv
// Round-robin arbiter with rotating priority pointer and a valid/ready lock that
// keeps a grant stable until the downstream accepts it.
module rv_rr_grant_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int LOCK_ENABLE  = 1,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    ready_in,
  output logic                    grant_valid,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic                    fire
);

  typedef enum logic {ARB, LOCKED} state_e;

  localparam logic [LOG_NUM_REQS:0] NUM_W = NUM_REQS[LOG_NUM_REQS:0];

  state_e                  state_q;
  logic [LOG_NUM_REQS-1:0] rr_ptr_q;
  logic [LOG_NUM_REQS-1:0] held_idx_q;

  logic [LOG_NUM_REQS-1:0] start_idx;
  logic [NUM_REQS-1:0]     rotated;
  logic                    pe_valid;
  logic [LOG_NUM_REQS-1:0] pe_idx;
  logic [LOG_NUM_REQS-1:0] arb_idx;
  logic                    held_req;

  // (a + b) mod NUM_REQS; one compare-subtract suffices since both operands are < NUM_REQS.
  function automatic logic [LOG_NUM_REQS-1:0] mod_add(input logic [LOG_NUM_REQS-1:0] a,
                                                      input logic [LOG_NUM_REQS-1:0] b);
    logic [LOG_NUM_REQS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NUM_W) s = s - NUM_W;
    return s[LOG_NUM_REQS-1:0];
  endfunction

  assign start_idx = mod_add(rr_ptr_q, LOG_NUM_REQS'(1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_rot
      assign rotated[gi] = requests[mod_add(LOG_NUM_REQS'(gi), start_idx)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the highest-priority requester.
  always_comb begin
    pe_valid = 1'b0;
    pe_idx   = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        pe_valid = 1'b1;
        pe_idx   = LOG_NUM_REQS'(i);
      end
    end
  end

  assign arb_idx  = mod_add(pe_idx, start_idx);
  assign held_req = requests[held_idx_q];

  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    if (!reset) begin
      if (state_q == LOCKED) begin
        grant_valid = held_req;
        grant_index = held_req ? held_idx_q : '0;
      end else begin
        grant_valid = pe_valid;
        grant_index = pe_valid ? arb_idx : '0;
      end
    end
  end

  assign fire = grant_valid & ready_in;

  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_valid && (grant_index == LOG_NUM_REQS'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      rr_ptr_q   <= LOG_NUM_REQS'(NUM_REQS - 1);
      held_idx_q <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (fire) begin
            rr_ptr_q <= arb_idx;
          end else if (grant_valid && (LOCK_ENABLE != 0)) begin
            held_idx_q <= arb_idx;
            state_q    <= LOCKED;
          end
        end
        LOCKED: begin
          // A withdrawn request releases the lock without moving the pointer.
          if (fire) begin
            rr_ptr_q <= held_idx_q;
            state_q  <= ARB;
          end else if (!held_req) begin
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_rr_grant_arbiter.sv
// Self-checking bench: three arbiter instances (N=4 locking, N=3 locking, N=4 non-locking)
// compared each cycle against a search-based reference model, plus literal directed checks.
module tb_rv_rr_grant_arbiter;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] req4  = '0;
  logic [2:0] req3  = '0;

  logic       v4, f4, v3, f3, vn, fn;
  logic [3:0] oh4, ohn;
  logic [2:0] oh3;
  logic [1:0] ix4, ix3, ixn;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rv_rr_grant_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(1)) dut4 (
    .clk(clk), .reset(reset), .requests(req4), .ready_in(ready),
    .grant_valid(v4), .grant_onehot(oh4), .grant_index(ix4), .fire(f4));

  rv_rr_grant_arbiter #(.NUM_REQS(3), .LOCK_ENABLE(1)) dut3 (
    .clk(clk), .reset(reset), .requests(req3), .ready_in(ready),
    .grant_valid(v3), .grant_onehot(oh3), .grant_index(ix3), .fire(f3));

  rv_rr_grant_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(0)) dutn (
    .clk(clk), .reset(reset), .requests(req4), .ready_in(ready),
    .grant_valid(vn), .grant_onehot(ohn), .grant_index(ixn), .fire(fn));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: last-served pointer, lock flag and held index per instance.
  int m_ptr[3];
  int m_held[3];
  bit m_lock[3];
  int m_n[3]  = '{4, 3, 4};
  bit m_le[3] = '{1'b1, 1'b1, 1'b0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int  r, av, ai, ao, af, ev, ei;
      string tag;
      case (k)
        0: begin r = int'(req4); av = int'(v4); ai = int'(ix4); ao = int'(oh4); af = int'(f4); tag = "n4"; end
        1: begin r = int'(req3); av = int'(v3); ai = int'(ix3); ao = int'(oh3); af = int'(f3); tag = "n3"; end
        default: begin r = int'(req4); av = int'(vn); ai = int'(ixn); ao = int'(ohn); af = int'(fn); tag = "n4nolock"; end
      endcase
      ev = 0;
      ei = 0;
      if (!reset) begin
        if (m_lock[k]) begin
          ev = (r >> m_held[k]) & 1;
          ei = ev ? m_held[k] : 0;
        end else begin
          for (int s = 1; s <= m_n[k]; s++) begin
            int c;
            c = (m_ptr[k] + s) % m_n[k];
            if (ev == 0 && ((r >> c) & 1) == 1) begin
              ev = 1;
              ei = c;
            end
          end
        end
      end
      check({tag, " model valid"},  av, ev);
      check({tag, " model index"},  ai, ei);
      check({tag, " model onehot"}, ao, ev ? (1 << ei) : 0);
      check({tag, " model fire"},   af, (ev != 0 && ready) ? 1 : 0);
      if (reset) begin
        m_ptr[k]  = m_n[k] - 1;
        m_lock[k] = 1'b0;
        m_held[k] = 0;
      end else if (m_lock[k]) begin
        if (ev != 0 && ready) begin
          m_ptr[k]  = m_held[k];
          m_lock[k] = 1'b0;
        end else if (ev == 0) begin
          m_lock[k] = 1'b0;
        end
      end else if (ev != 0) begin
        if (ready) m_ptr[k] = ei;
        else if (m_le[k]) begin
          m_lock[k] = 1'b1;
          m_held[k] = ei;
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic [3:0] r4, input logic [2:0] r3, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst;
    req4  = r4;
    req3  = r3;
    ready = rdy;
    @(negedge clk);
  endtask

  task automatic expect4(input string name, input int v, input int idx, input int f);
    check({name, " valid"}, int'(v4), v);
    check({name, " index"}, int'(ix4), idx);
    check({name, " fire"},  int'(f4), f);
  endtask

  int seq_all[6] = '{0, 1, 2, 3, 0, 1};
  int seq_3[6]   = '{0, 1, 2, 0, 1, 2};
  int seq_alt[4] = '{1, 3, 1, 3};

  initial begin
    drive(1'b1, 4'b1111, 3'b111, 1'b1);
    expect4("reset", 0, 0, 0);
    check("reset onehot", int'(oh4), 0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b1111, 3'b111, 1'b1);
      expect4($sformatf("all-req step%0d", i), 1, seq_all[i], 1);
      check($sformatf("n3 all-req step%0d", i), int'(ix3), seq_3[i]);
    end

    drive(1'b1, 4'b0000, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1010, 3'b000, 1'b1);
      expect4($sformatf("alt step%0d", i), 1, seq_alt[i], 1);
    end

    drive(1'b1, 4'b0000, 3'b000, 1'b0);
    drive(1'b0, 4'b0011, 3'b000, 1'b0);
    expect4("lock c0", 1, 0, 0);
    drive(1'b0, 4'b1011, 3'b000, 1'b0);
    expect4("lock c1", 1, 0, 0);
    drive(1'b0, 4'b1011, 3'b000, 1'b0);
    expect4("lock c2", 1, 0, 0);
    drive(1'b0, 4'b1011, 3'b000, 1'b1);
    expect4("lock accept", 1, 0, 1);
    drive(1'b0, 4'b0011, 3'b000, 1'b1);
    expect4("after lock", 1, 1, 1);

    drive(1'b1, 4'b0000, 3'b000, 1'b0);
    drive(1'b0, 4'b0100, 3'b000, 1'b0);
    expect4("withdraw lock", 1, 2, 0);
    drive(1'b0, 4'b1011, 3'b000, 1'b0);
    expect4("withdraw drop", 0, 0, 0);
    drive(1'b0, 4'b1011, 3'b000, 1'b0);
    expect4("withdraw resume", 1, 0, 0);

    drive(1'b1, 4'b0000, 3'b000, 1'b0);
    drive(1'b0, 4'b0100, 3'b000, 1'b0);
    expect4("midlock grant", 1, 2, 0);
    drive(1'b1, 4'b1111, 3'b000, 1'b1);
    expect4("midlock reset", 0, 0, 0);
    check("midlock reset onehot", int'(oh4), 0);
    drive(1'b0, 4'b1111, 3'b000, 1'b0);
    expect4("after midlock reset", 1, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 99) == 0, 4'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
